// File: rtl/proj_to_affine.sv
// Projective-to-affine converter: binary extended-Euclid inversion of Z followed by
// bit-serial modular multiplies. COORD selects homogeneous (X/Z) or Jacobian (X/Z^2, Y/Z^3).
module proj_to_affine #(
  parameter int W     = 256,
  parameter int COORD = 0
) (
  input  logic         i_clk,
  input  logic         i_rst_n,
  input  logic         i_start,
  input  logic [W-1:0] X,
  input  logic [W-1:0] Y,
  input  logic [W-1:0] Z,
  input  logic [W-1:0] p,
  output logic [W-1:0] x_aff,
  output logic [W-1:0] y_aff,
  output logic         o_infinity,
  output logic         o_busy,
  output logic         o_done
);
  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_CHECK = 3'd1;
  localparam logic [2:0] S_INV   = 3'd2;
  localparam logic [2:0] S_MUL   = 3'd3;
  localparam logic [2:0] S_DONE  = 3'd4;

  localparam int             CW       = $clog2(2*W+1);
  localparam logic [CW-1:0]  BIT_LAST = CW'(W-1);
  localparam logic [CW-1:0]  INV_LAST = CW'(2*W-1);
  localparam logic [1:0]     OP_LAST  = (COORD == 1) ? 2'd3 : 2'd1;
  localparam logic [W-1:0]   ONE      = W'(1);

  logic [2:0]    r_state;
  logic [W-1:0]  r_X, r_Y, r_p, r_u, r_v, r_a, r_b;
  logic [W-1:0]  r_zi, r_t, r_x, r_ma, r_sh, r_acc;
  logic [CW-1:0] r_cnt;
  logic [1:0]    r_op;

  logic [W-1:0]  w_u_n, w_v_n, w_a_n, w_b_n, w_zi, w_r1, w_prod;
  logic [W+1:0]  w_add;
  logic          w_inv_exit, w_mul_last;

  // t/2 mod p for odd p: an odd t is made even by adding p first (needs W+1 bits)
  function automatic logic [W-1:0] f_half(input logic [W-1:0] t, input logic [W-1:0] m);
    logic [W:0] s;
    s = t[0] ? ({1'b0, t} + {1'b0, m}) : {1'b0, t};
    return W'(s >> 1);
  endfunction

  function automatic logic [W-1:0] f_subm(input logic [W-1:0] a, input logic [W-1:0] b,
                                          input logic [W-1:0] m);
    logic [W:0] d;
    d = {1'b0, a} - {1'b0, b};
    if (a < b) d = d + {1'b0, m};
    return W'(d);
  endfunction

  function automatic logic [W-1:0] f_red(input logic [W+1:0] t, input logic [W-1:0] m);
    return W'((t >= {2'b00, m}) ? (t - {2'b00, m}) : t);
  endfunction

  always_comb begin
    w_u_n = r_u;
    w_v_n = r_v;
    w_a_n = r_a;
    w_b_n = r_b;
    if (!r_u[0]) begin
      w_u_n = r_u >> 1;
      w_a_n = f_half(r_a, r_p);
    end else if (!r_v[0]) begin
      w_v_n = r_v >> 1;
      w_b_n = f_half(r_b, r_p);
    end else if (r_u >= r_v) begin
      w_u_n = r_u - r_v;
      w_a_n = f_subm(r_a, r_b, r_p);
    end else begin
      w_v_n = r_v - r_u;
      w_b_n = f_subm(r_b, r_a, r_p);
    end
  end

  // the step count cap keeps the FSM finite for non-invertible or out-of-range inputs
  assign w_inv_exit = (w_u_n == ONE) || (w_v_n == ONE) || (r_cnt == INV_LAST);
  assign w_zi       = (w_u_n == ONE) ? w_a_n : w_b_n;

  assign w_r1       = f_red({1'b0, r_acc, 1'b0}, r_p);
  assign w_add      = {2'b00, w_r1} + (r_sh[W-1] ? {2'b00, r_ma} : {(W+2){1'b0}});
  assign w_prod     = f_red(w_add, r_p);
  assign w_mul_last = (r_cnt == BIT_LAST);

  assign o_busy = (r_state != S_IDLE);
  assign o_done = (r_state == S_DONE);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state    <= S_IDLE;
      r_X        <= '0;
      r_Y        <= '0;
      r_p        <= '0;
      r_u        <= '0;
      r_v        <= '0;
      r_a        <= '0;
      r_b        <= '0;
      r_zi       <= '0;
      r_t        <= '0;
      r_x        <= '0;
      r_ma       <= '0;
      r_sh       <= '0;
      r_acc      <= '0;
      r_cnt      <= '0;
      r_op       <= '0;
      x_aff      <= '0;
      y_aff      <= '0;
      o_infinity <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: if (i_start) begin
          r_X     <= X;
          r_Y     <= Y;
          r_u     <= Z;
          r_p     <= p;
          r_state <= S_CHECK;
        end
        S_CHECK: if (r_u == '0) begin
          x_aff      <= '0;
          y_aff      <= '0;
          o_infinity <= 1'b1;
          r_state    <= S_DONE;
        end else begin
          r_v     <= r_p;
          r_a     <= ONE;
          r_b     <= '0;
          r_cnt   <= '0;
          r_state <= S_INV;
        end
        S_INV: if (w_inv_exit) begin
          r_zi    <= w_zi;
          r_ma    <= (COORD == 1) ? w_zi : r_X;
          r_sh    <= w_zi;
          r_acc   <= '0;
          r_cnt   <= '0;
          r_op    <= '0;
          r_state <= S_MUL;
        end else begin
          r_u   <= w_u_n;
          r_v   <= w_v_n;
          r_a   <= w_a_n;
          r_b   <= w_b_n;
          r_cnt <= r_cnt + 1'b1;
        end
        S_MUL: begin
          r_acc <= w_prod;
          r_sh  <= r_sh << 1;
          r_cnt <= r_cnt + 1'b1;
          if (w_mul_last) begin
            r_acc <= '0;
            r_cnt <= '0;
            r_op  <= r_op + 2'd1;
            if (r_op == OP_LAST) begin
              x_aff      <= r_x;
              y_aff      <= w_prod;
              o_infinity <= 1'b0;
              r_state    <= S_DONE;
            end else if (COORD == 1) begin
              // Jacobian chain: zi^2, X*zi^2, zi^3, Y*zi^3
              case (r_op)
                2'd0: begin r_t <= w_prod; r_ma <= r_X; r_sh <= w_prod; end
                2'd1: begin r_x <= w_prod; r_ma <= r_t; r_sh <= r_zi;   end
                default: begin r_ma <= r_Y; r_sh <= w_prod; end
              endcase
            end else begin
              r_x  <= w_prod;
              r_ma <= r_Y;
              r_sh <= r_zi;
            end
          end
        end
        S_DONE:  r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_proj_to_affine.sv
// Bench for proj_to_affine at W=8, p=23: one instance per coordinate system,
// directed vector table, busy/reset corner sequences and a sweep over every nonzero Z.
module tb_proj_to_affine;
  localparam int W = 8;
  localparam int P = 23;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         st0 = 1'b0, st1 = 1'b0;
  logic [W-1:0] X0 = '0, Y0 = '0, Z0 = '0, X1 = '0, Y1 = '0, Z1 = '0;
  logic [W-1:0] pp = W'(P);
  logic [W-1:0] xa0, ya0, xa1, ya1;
  logic         inf0, inf1, busy0, busy1, done0, done1;

  always #5 clk = ~clk;

  proj_to_affine #(.W(W), .COORD(0)) u_dut0 (
    .i_clk(clk), .i_rst_n(rst_n), .i_start(st0), .X(X0), .Y(Y0), .Z(Z0), .p(pp),
    .x_aff(xa0), .y_aff(ya0), .o_infinity(inf0), .o_busy(busy0), .o_done(done0));

  proj_to_affine #(.W(W), .COORD(1)) u_dut1 (
    .i_clk(clk), .i_rst_n(rst_n), .i_start(st1), .X(X1), .Y(Y1), .Z(Z1), .p(pp),
    .x_aff(xa1), .y_aff(ya1), .o_infinity(inf1), .o_busy(busy1), .o_done(done1));

  typedef struct {int coord; int x; int y; int z; int ex; int ey; int einf;} vec_t;
  typedef struct {int ex; int ey; int einf; int lat;} exp_t;

  exp_t sb_q[$];
  int   n_tests = 0;
  int   n_fail  = 0;
  int   prev_x[2], prev_y[2];

  task automatic chk(input string name, input int act, input int req);
    n_tests++;
    if (act != req) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, req);
    end
  endtask

  task automatic set_in(input int c, input int x, input int y, input int z, input logic s);
    if (c == 0) begin X0 = W'(x); Y0 = W'(y); Z0 = W'(z); st0 = s; end
    else        begin X1 = W'(x); Y1 = W'(y); Z1 = W'(z); st1 = s; end
  endtask

  task automatic set_start(input int c, input logic s);
    if (c == 0) st0 = s; else st1 = s;
  endtask

  function automatic int get_x(input int c);    return c ? int'(xa1) : int'(xa0); endfunction
  function automatic int get_y(input int c);    return c ? int'(ya1) : int'(ya0); endfunction
  function automatic int get_inf(input int c);  return c ? int'(inf1) : int'(inf0); endfunction
  function automatic int get_busy(input int c); return c ? int'(busy1) : int'(busy0); endfunction
  function automatic int get_done(input int c); return c ? int'(done1) : int'(done0); endfunction

  function automatic int inv_mod(input int z);
    for (int i = 1; i < P; i++) if ((z * i) % P == 1) return i;
    return 0;
  endfunction

  // number of Euclid steps: branching depends only on u and v
  function automatic int inv_steps(input int z);
    int u, v, n;
    u = z; v = P; n = 0;
    while (n < 2*W) begin
      if (u % 2 == 0)      u = u / 2;
      else if (v % 2 == 0) v = v / 2;
      else if (u >= v)     u = u - v;
      else                 v = v - u;
      n++;
      if (u == 1 || v == 1) break;
    end
    return n;
  endfunction

  function automatic int pow_mod(input int b, input int e);
    int r;
    r = 1;
    for (int i = 0; i < e; i++) r = (r * b) % P;
    return r;
  endfunction

  function automatic exp_t model(input int c, input int x, input int y, input int z);
    exp_t e;
    int zi;
    if (z == 0) begin
      e.ex = 0; e.ey = 0; e.einf = 1; e.lat = 2;
    end else begin
      zi     = inv_mod(z);
      e.ex   = (x * pow_mod(zi, c ? 2 : 1)) % P;
      e.ey   = (y * pow_mod(zi, c ? 3 : 1)) % P;
      e.einf = 0;
      e.lat  = 2 + inv_steps(z) + (c ? 4 : 2) * W;
    end
    return e;
  endfunction

  // glitch > 0: extra start pulse (junk inputs) at that busy cycle; glitch < 0: pulse in the done cycle
  task automatic run_vec(input vec_t v, input int glitch);
    exp_t e, got;
    int   n;
    bit   seen;
    e = model(v.coord, v.x, v.y, v.z);
    if (v.ex >= 0) begin e.ex = v.ex; e.ey = v.ey; e.einf = v.einf; end
    sb_q.push_back(e);
    @(negedge clk); set_in(v.coord, v.x, v.y, v.z, 1'b1);
    @(negedge clk); set_start(v.coord, 1'b0);
    chk("busy_after_start", get_busy(v.coord), 1);
    chk("x_hold_while_busy", get_x(v.coord), prev_x[v.coord]);
    n = 1; seen = 0;
    while (n < 400) begin
      if (get_done(v.coord) != 0) begin seen = 1; break; end
      if (n == glitch) set_in(v.coord, 1, 2, 1, 1'b1);
      @(negedge clk); set_start(v.coord, 1'b0);
      n++;
    end
    got = sb_q.pop_front();
    chk("done_seen", int'(seen), 1);
    if (seen) begin
      chk("latency", n, got.lat);
      chk("x_aff", get_x(v.coord), got.ex);
      chk("y_aff", get_y(v.coord), got.ey);
      chk("o_infinity", get_inf(v.coord), got.einf);
      chk("busy_in_done", get_busy(v.coord), 1);
      if (v.z != 0) begin
        chk("x_times_zk", (get_x(v.coord) * pow_mod(v.z, v.coord ? 2 : 1)) % P, v.x % P);
        chk("y_times_zk", (get_y(v.coord) * pow_mod(v.z, v.coord ? 3 : 1)) % P, v.y % P);
      end
      if (glitch < 0) set_in(v.coord, 1, 2, 1, 1'b1);
      @(negedge clk); set_start(v.coord, 1'b0);
      chk("done_one_cycle", get_done(v.coord), 0);
      chk("idle_after_done", get_busy(v.coord), 0);
      @(negedge clk);
      chk("no_restart", get_busy(v.coord), 0);
      chk("x_hold_idle", get_x(v.coord), got.ex);
    end
    prev_x[v.coord] = got.ex;
    prev_y[v.coord] = got.ey;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t tab[6];
    vec_t r;
    int   dcnt;

    tab[0] = '{coord:0, x:3,  y:7, z:5,  ex:19, ey:6,  einf:0};
    tab[1] = '{coord:1, x:3,  y:7, z:5,  ex:13, ey:3,  einf:0};
    tab[2] = '{coord:0, x:17, y:4, z:1,  ex:17, ey:4,  einf:0};
    tab[3] = '{coord:0, x:1,  y:2, z:22, ex:22, ey:21, einf:0};
    tab[4] = '{coord:0, x:0,  y:1, z:0,  ex:0,  ey:0,  einf:1};
    tab[5] = '{coord:1, x:0,  y:1, z:0,  ex:0,  ey:0,  einf:1};
    prev_x = '{0, 0};
    prev_y = '{0, 0};

    repeat (3) @(negedge clk);
    for (int c = 0; c < 2; c++) begin
      chk("rst_x_aff", get_x(c), 0);
      chk("rst_y_aff", get_y(c), 0);
      chk("rst_inf", get_inf(c), 0);
      chk("rst_busy", get_busy(c), 0);
      chk("rst_done", get_done(c), 0);
    end
    rst_n = 1'b1;

    for (int i = 0; i < 6; i++) run_vec(tab[i], 0);

    // second start while busy, then start coinciding with done
    run_vec(tab[0], 6);
    run_vec(tab[1], -1);

    // reset while the inverter is running
    @(negedge clk); set_in(0, 3, 7, 5, 1'b1);
    @(negedge clk); set_start(0, 1'b0);
    repeat (3) @(negedge clk);
    chk("busy_before_rst", int'(busy0), 1);
    rst_n = 1'b0;
    #1;
    chk("rst_mid_x", int'(xa0), 0);
    chk("rst_mid_y", int'(ya0), 0);
    chk("rst_mid_busy", int'(busy0), 0);
    chk("rst_mid_x1", int'(xa1), 0);
    @(negedge clk); rst_n = 1'b1;
    dcnt = 0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (done0) dcnt++;
    end
    chk("no_done_after_rst", dcnt, 0);
    chk("idle_after_rst", int'(busy0), 0);
    prev_x = '{0, 0};
    prev_y = '{0, 0};

    for (int z = 1; z < P; z++) begin
      for (int c = 0; c < 2; c++) begin
        r = '{coord:c, x:$urandom_range(0, P-1), y:$urandom_range(0, P-1), z:z, ex:-1, ey:-1, einf:0};
        run_vec(r, 0);
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
